// File: rtl/pixel_plot_sink.sv
// Plot-request sink for the 160x120 VGA framebuffer: buffers (x, y, colour)
// requests, drops off-screen ones, and drives the adapter plot port; also runs full-screen clears.
module pixel_plot_sink #(
  parameter int X_MAX      = 160,
  parameter int Y_MAX      = 120,
  parameter int COLOUR_W   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_x,
  input  logic [6:0]          in_y,
  input  logic [COLOUR_W-1:0] in_colour,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic [7:0]          clip_count,
  output logic [1:0]          state_dbg
);

  // Handshake: a request transfers on a rising edge with in_valid & in_ready;
  // in_ready depends only on registered state, never on in_valid.

  typedef enum logic [1:0] {RUN = 2'd0, CLR_WAIT = 2'd1, CLEAR = 2'd2} state_t;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 8 + 7 + COLOUR_W;
  localparam logic [7:0]    X_LAST = 8'(X_MAX - 1);
  localparam logic [6:0]    Y_LAST = 7'(Y_MAX - 1);
  localparam logic [PW-1:0] P_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  state_t                state_q, state_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            vga_x_q, vga_x_d;
  logic [6:0]            vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
  logic                  vga_plot_q, vga_plot_d;
  logic [7:0]            clip_count_q, clip_count_d;
  logic [7:0]            clr_x_q, clr_x_d;
  logic [6:0]            clr_y_q, clr_y_d;
  logic [COLOUR_W-1:0]   clr_colour_q, clr_colour_d;

  logic          accept, on_screen, push, pop;
  logic [EW-1:0] head;

  always_comb begin
    in_ready  = (state_q == RUN) && (count_q != C_FULL);
    accept    = in_valid && in_ready;
    on_screen = (in_x <= X_LAST) && (in_y <= Y_LAST);
    push      = accept && on_screen;
    pop       = (state_q != CLEAR) && (count_q != '0);
    head      = mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    clip_count_d = clip_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = {in_x, in_y, in_colour};
      wr_ptr_d        = (wr_ptr_q == P_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == P_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (accept && !on_screen && (clip_count_q != 8'hFF)) begin
      clip_count_d = clip_count_q + 8'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    clr_x_d      = clr_x_q;
    clr_y_d      = clr_y_q;
    clr_colour_d = clr_colour_q;

    if (pop) begin
      {vga_x_d, vga_y_d, vga_colour_d} = head;
      vga_plot_d = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (clear_req) begin
          state_d      = CLR_WAIT;
          clr_colour_d = clear_colour;
        end
      end
      CLR_WAIT: begin
        // Nothing can be pushed here, so at most one entry means empty after this edge.
        if (count_q <= CW'(1)) begin
          state_d = CLEAR;
          clr_x_d = '0;
          clr_y_d = '0;
        end
      end
      CLEAR: begin
        vga_x_d      = clr_x_q;
        vga_y_d      = clr_y_q;
        vga_colour_d = clr_colour_q;
        vga_plot_d   = 1'b1;
        if (clr_x_q == X_LAST) begin
          clr_x_d = '0;
          if (clr_y_q == Y_LAST) begin
            clr_y_d = '0;
            state_d = RUN;
          end else begin
            clr_y_d = clr_y_q + 7'd1;
          end
        end else begin
          clr_x_d = clr_x_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      clip_count_q <= '0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      clr_colour_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      clip_count_q <= clip_count_d;
      clr_x_q      <= clr_x_d;
      clr_y_q      <= clr_y_d;
      clr_colour_q <= clr_colour_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign clip_count = clip_count_q;
  assign busy       = (state_q != RUN) || (count_q != '0);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: expected strobes go into a queue,
// a negedge monitor pops and compares every vga_plot strobe.
module tb_pixel_plot_sink;

  localparam int W = 18;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic [7:0] clip_count;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int strobes = 0;

  pixel_plot_sink dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .clear_req(clear_req), .clear_colour(clear_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .clip_count(clip_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (vga_plot === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got (%0d,%0d,%0d), expected no strobe",
                 vga_x, vga_y, vga_colour);
      end else begin
        check("plot_xyc", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_push(input int x, input int y, input int c);
    exp_q.push_back({8'(x), 7'(y), 3'(c)});
  endtask

  task automatic set_req(input int x, input int y, input int c);
    in_valid  = 1'b1;
    in_x      = 8'(x);
    in_y      = 7'(y);
    in_colour = 3'(c);
    if (x < 160 && y < 120) exp_push(x, y, c);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic push_clear(input int n, input int c);
    for (int i = 0; i < n; i++) exp_push(i % 160, i / 160, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    bit ready_low_ok;
    bit done;

    reset = 1'b1;
    in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
    clear_req = 1'b0; clear_colour = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_vga_plot", 32'(vga_plot), 32'd0);
    check("rst_vga_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clip_count", 32'(clip_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // single request latency
    set_req(10, 20, 3);
    tick();                       // edge N
    idle();
    check("t1_no_plot_at_N", 32'(vga_plot), 32'd0);
    tick();                       // edge N+1
    check("t1_plot_at_N1", 32'(vga_plot), 32'd1);
    check("t1_xyc_at_N1", 32'({vga_x, vga_y, vga_colour}), 32'({8'd10, 7'd20, 3'd3}));
    tick();                       // edge N+2
    check("t1_plot_off_N2", 32'(vga_plot), 32'd0);
    check("t1_busy_N2", 32'(busy), 32'd0);

    // burst of 6 back-to-back requests
    s0 = strobes;
    for (int i = 0; i < 6; i++) begin
      set_req(i * 20 + 1, i * 15 + 2, i + 1);
      check("t2_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    idle();
    tick();
    check("t2_drained_busy", 32'(busy), 32'd0);
    @(negedge clock); #1;
    check("t2_strobes", 32'(strobes - s0), 32'd6);

    // clipping boundaries
    set_req(159, 119, 1); tick();
    set_req(160, 0, 2);   tick();
    set_req(0, 120, 3);   tick();
    set_req(255, 127, 4); tick();
    idle();
    tick(); tick();
    check("t3_clip_3", 32'(clip_count), 32'd3);
    for (int i = 0; i < 260; i++) begin
      set_req(160 + (i % 96), i % 128, i % 8);
      tick();
    end
    idle();
    tick();
    check("t3_clip_sat", 32'(clip_count), 32'd255);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // queued requests, clear on same edge as the 4th, second clear_req ignored
    s0 = strobes;
    set_req(30, 40, 1); tick();
    set_req(31, 41, 2); tick();
    set_req(32, 42, 3); tick();
    set_req(33, 43, 4);
    clear_req = 1'b1;
    clear_colour = 3'd5;
    check("t4_ready_before_clear", 32'(in_ready), 32'd1);
    tick();
    idle();
    clear_colour = 3'd0;
    push_clear(19200, 5);
    ready_low_ok = 1'b1;
    done = 1'b0;
    for (int cyc = 0; cyc < 25000 && !done; cyc++) begin
      if (state_dbg == 2'd0) begin
        done = 1'b1;
      end else begin
        if (in_ready) ready_low_ok = 1'b0;
        clear_req = (cyc == 3000);
        clear_colour = (cyc == 3000) ? 3'd7 : 3'd0;
        tick();
      end
    end
    clear_req = 1'b0;
    check("t4_clear_finished", 32'(done), 32'd1);
    check("t4_ready_low_during", 32'(ready_low_ok), 32'd1);
    check("t4_ready_after", 32'(in_ready), 32'd1);
    @(negedge clock); #1;
    check("t4_strobes", 32'(strobes - s0), 32'd19204);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (4) tick();
    check("t4_no_extra", 32'(strobes - s0), 32'd19204);

    // reset in the middle of a clear
    s0 = strobes;
    clear_req = 1'b1;
    clear_colour = 3'd2;
    tick();
    clear_req = 1'b0;
    push_clear(5000, 2);
    done = 1'b0;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clock); #1;
      if (strobes - s0 >= 5000) done = 1'b1;
    end
    check("t6_reached_5000", 32'(done), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_plot_async_off", 32'(vga_plot), 32'd0);
    check("t6_state_run", 32'(state_dbg), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_clip_cleared", 32'(clip_count), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (5) tick();
    check("t6_no_more_strobes", 32'(strobes - s0), 32'd5000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
